dp_ram_clr: RTL and testbench
=============================

DP_RAM_CLR -- requirements
Module: dp_ram_clr

Interface
REQ-001 SHALL have parameter SIZE, default 16, data word width in bits; SIZE SHALL be a multiple of LANE.
REQ-002 SHALL have parameter DEPTH, default 64, number of entries; DEPTH SHALL be a power of two and at least 2.
REQ-003 SHALL have parameter LANE, default 8, width in bits of one write-mask lane; NL = SIZE/LANE.
REQ-004 SHALL have parameter RDW_MODE, default 0, same-address read-during-write result: 0 = old data, 1 = new data.
REQ-005 SHALL have parameter CLR_VAL, default 0, SIZE-bit value written to every entry after reset.
REQ-006 SHALL have port clk, input, 1 bit, the single clock; all logic on its rising edge.
REQ-007 SHALL have port rst, input, 1 bit, reset, synchronous and active-high.
REQ-008 SHALL have port wr_en, input, 1 bit, write request.
REQ-009 SHALL have port wr_addr, input, $clog2(DEPTH) bits, write address.
REQ-010 SHALL have port wr_data, input, SIZE bits, write data.
REQ-011 SHALL have port wr_mask, input, NL bits, lane enables; bit i covers wr_data[i*LANE +: LANE].
REQ-012 SHALL have port rd_en, input, 1 bit, read request.
REQ-013 SHALL have port rd_addr, input, $clog2(DEPTH) bits, read address.
REQ-014 SHALL have port rd_data, output, SIZE bits, registered read data.
REQ-015 SHALL have port rd_valid, output, 1 bit, rd_data updated this cycle.
REQ-016 SHALL have port busy, output, 1 bit, high while the clear sweep runs.

Function
REQ-017 SHALL implement a two-state FSM, CLEAR and READY; reset enters CLEAR with the sweep counter at 0.
REQ-018 In CLEAR, SHALL write CLR_VAL to the entry at the counter each cycle and increment the counter; after writing entry DEPTH-1 it SHALL enter READY; CLEAR lasts exactly DEPTH cycles.
REQ-019 busy SHALL be 1 in CLEAR and 0 in READY (registered state, no combinational path from inputs).
REQ-020 In CLEAR, wr_en and rd_en SHALL be ignored: no user write, rd_valid = 0, rd_data held.
REQ-021 In READY, wr_en = 1 SHALL update only the lanes of entry wr_addr whose wr_mask bit is 1; other lanes keep their value; wr_mask = 0 writes nothing.
REQ-022 In READY, rd_en = 1 in cycle n SHALL present the entry at rd_addr on rd_data in cycle n+1 with rd_valid = 1 (latency 1).
REQ-023 rd_valid SHALL be 0 in any cycle not following an accepted read; rd_data SHALL hold its last value when no read is accepted.
REQ-024 On a same-cycle read and write to the same address with RDW_MODE = 0, rd_data SHALL return the pre-write entry.
REQ-025 On a same-cycle read and write to the same address with RDW_MODE = 1, rd_data SHALL return the merged value: masked lanes from wr_data, unmasked lanes from the stored entry.
REQ-026 Reads and writes to different addresses in the same cycle SHALL both complete independently.
REQ-027 Back-to-back reads SHALL sustain one result per cycle; back-to-back writes one per cycle.

Reset
REQ-028 rst = 1 SHALL set, at the next edge: state CLEAR, counter 0, busy 1, rd_valid 0, rd_data 0.
REQ-029 rst asserted during CLEAR SHALL restart the sweep from entry 0; during READY it SHALL abandon pending reads, with no rd_valid the following cycle.
REQ-030 Memory contents SHALL be defined only by the sweep; no other reset of the array is required.

Verification
REQ-031 Defaults, release rst -> busy = 1 for exactly 64 cycles, then 0; reads of entries 0, 31, 63 return 0x0000.
REQ-032 Write 0xABCD to address 5 with wr_mask = 2'b01, then read 5 -> 0x00CD one cycle after rd_en with rd_valid = 1; then write 0x1200 with mask 2'b10, read -> 0x12CD.
REQ-033 Address 7 holds 0x1111; same cycle: write 0x2222 (mask 11) and read 7 -> 0x1111 with RDW_MODE = 0, 0x2222 with RDW_MODE = 1.
REQ-034 rst pulsed at sweep cycle 30 -> busy stays high 64 more cycles; a wr_en issued during the sweep leaves the target entry at CLR_VAL.
REQ-035 Streaming reads of addresses 0..63 on consecutive cycles after distinct writes -> 64 consecutive rd_valid pulses with matching data; rd_valid drops the cycle after rd_en falls.

Source files
------------

// File: rtl/dp_ram_clr.sv
// Dual-port RAM with per-lane write mask and a post-reset clear sweep.
// One entry per cycle is swept to CLR_VAL; user traffic is accepted only once the sweep completes.
module dp_ram_clr #(
   parameter int              SIZE     = 16,
   parameter int              DEPTH    = 64,
   parameter int              LANE     = 8,
   parameter int              RDW_MODE = 0,
   parameter logic [SIZE-1:0] CLR_VAL  = '0
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     wr_en,
   input  logic [$clog2(DEPTH)-1:0] wr_addr,
   input  logic [SIZE-1:0]          wr_data,
   input  logic [SIZE/LANE-1:0]     wr_mask,
   input  logic                     rd_en,
   input  logic [$clog2(DEPTH)-1:0] rd_addr,
   output logic [SIZE-1:0]          rd_data,
   output logic                     rd_valid,
   output logic                     busy
);

   localparam int NL = SIZE / LANE;
   localparam int AW = $clog2(DEPTH);

   typedef enum logic {CLEAR, READY} state_t;

   state_t          r_state;
   logic [AW-1:0]   r_cnt;
   logic [SIZE-1:0] r_mem [DEPTH];
   logic [SIZE-1:0] r_rdData;
   logic            r_rdValid;
   logic            r_busy;

   logic            w_clrWe;
   logic            w_userWe;
   logic            w_sameAddr;
   logic [SIZE-1:0] w_merged;
   logic [SIZE-1:0] w_rdWord;

   assign w_clrWe    = (r_state == CLEAR) && !rst;
   assign w_userWe   = (r_state == READY) && !rst && wr_en;
   assign w_sameAddr = (wr_addr == rd_addr);

   // Stored read entry with the lanes of a same-cycle write overlaid, used for new-data RDW.
   always_comb begin
      w_merged = r_mem[rd_addr];
      for (int i = 0; i < NL; i++) begin
         if (wr_mask[i]) begin
            w_merged[i*LANE +: LANE] = wr_data[i*LANE +: LANE];
         end
      end
   end

   assign w_rdWord = (RDW_MODE != 0 && w_userWe && w_sameAddr) ? w_merged : r_mem[rd_addr];

   always_ff @(posedge clk) begin
      if (w_clrWe) begin
         r_mem[r_cnt] <= CLR_VAL;
      end else if (w_userWe) begin
         for (int i = 0; i < NL; i++) begin
            if (wr_mask[i]) begin
               r_mem[wr_addr][i*LANE +: LANE] <= wr_data[i*LANE +: LANE];
            end
         end
      end
   end

   // Sweep sequencing plus the registered read port; reads are dropped entirely while clearing.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= CLEAR;
         r_cnt     <= '0;
         r_busy    <= 1'b1;
         r_rdValid <= 1'b0;
         r_rdData  <= '0;
      end else begin
         case (r_state)
            CLEAR: begin
               r_rdValid <= 1'b0;
               r_cnt     <= r_cnt + AW'(1);
               if (r_cnt == AW'(DEPTH - 1)) begin
                  r_state <= READY;
                  r_busy  <= 1'b0;
               end
            end
            READY: begin
               r_busy    <= 1'b0;
               r_rdValid <= rd_en;
               if (rd_en) begin
                  r_rdData <= w_rdWord;
               end
            end
            default: begin
               r_state <= CLEAR;
               r_cnt   <= '0;
               r_busy  <= 1'b1;
            end
         endcase
      end
   end

   assign rd_data  = r_rdData;
   assign rd_valid = r_rdValid;
   assign busy     = r_busy;

endmodule

// File: tb/tb_dp_ram_clr.sv
// Random and directed stimulus for dp_ram_clr, driving old-data and new-data RDW instances in parallel.
// A lane-level array model predicts every output; directed literals pin the model itself.
module tb_dp_ram_clr;

   localparam int SIZE  = 16;
   localparam int DEPTH = 64;
   localparam int LANE  = 8;
   localparam int NL    = SIZE / LANE;
   localparam int AW    = $clog2(DEPTH);
   localparam logic [SIZE-1:0] CLR = 16'h0000;

   logic            clk = 1'b0;
   logic            rst;
   logic            wrEn;
   logic [AW-1:0]   wrAddr;
   logic [SIZE-1:0] wrData;
   logic [NL-1:0]   wrMask;
   logic            rdEn;
   logic [AW-1:0]   rdAddr;

   logic [SIZE-1:0] rdData0, rdData1;
   logic            rdValid0, rdValid1;
   logic            busy0, busy1;

   int vectors     = 0;
   int miscompares = 0;

   dp_ram_clr #(.SIZE(SIZE), .DEPTH(DEPTH), .LANE(LANE), .RDW_MODE(0), .CLR_VAL(CLR)) dutOld (
      .clk(clk), .rst(rst), .wr_en(wrEn), .wr_addr(wrAddr), .wr_data(wrData), .wr_mask(wrMask),
      .rd_en(rdEn), .rd_addr(rdAddr), .rd_data(rdData0), .rd_valid(rdValid0), .busy(busy0));

   dp_ram_clr #(.SIZE(SIZE), .DEPTH(DEPTH), .LANE(LANE), .RDW_MODE(1), .CLR_VAL(CLR)) dutNew (
      .clk(clk), .rst(rst), .wr_en(wrEn), .wr_addr(wrAddr), .wr_data(wrData), .wr_mask(wrMask),
      .rd_en(rdEn), .rd_addr(rdAddr), .rd_data(rdData1), .rd_valid(rdValid1), .busy(busy1));

   always #5 clk = ~clk;

   // Reference model: the array, how many sweep cycles remain, and the outputs expected after each edge.
   logic [SIZE-1:0] modelMem [DEPTH];
   int              sweepLeft = 0;
   logic            modelValid = 1'b0;
   logic            expBusy = 1'b0;
   logic            expValid = 1'b0;
   logic [SIZE-1:0] expData0 = '0;
   logic [SIZE-1:0] expData1 = '0;

   function automatic logic [SIZE-1:0] mergeLanes(input logic [SIZE-1:0] oldWord,
                                                  input logic [SIZE-1:0] newWord,
                                                  input logic [NL-1:0]   m);
      logic [SIZE-1:0] bitMask;
      for (int b = 0; b < SIZE; b++) bitMask[b] = m[b / LANE];
      return (oldWord & ~bitMask) | (newWord & bitMask);
   endfunction

   always @(posedge clk) begin : refModel
      if (rst) begin
         modelValid <= 1'b1;
         sweepLeft  <= DEPTH;
         expBusy    <= 1'b1;
         expValid   <= 1'b0;
         expData0   <= '0;
         expData1   <= '0;
      end else if (modelValid) begin
         if (sweepLeft > 0) begin
            modelMem[AW'(DEPTH - sweepLeft)] <= CLR;
            sweepLeft <= sweepLeft - 1;
            expBusy   <= (sweepLeft > 1);
            expValid  <= 1'b0;
         end else begin
            expBusy  <= 1'b0;
            expValid <= rdEn;
            if (wrEn) modelMem[wrAddr] <= mergeLanes(modelMem[wrAddr], wrData, wrMask);
            if (rdEn) begin
               expData0 <= modelMem[rdAddr];
               expData1 <= (wrEn && wrAddr == rdAddr) ? mergeLanes(modelMem[rdAddr], wrData, wrMask)
                                                      : modelMem[rdAddr];
            end
         end
      end
   end

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      vectors++;
      if (actual !== expected) begin
         miscompares++;
         $display("[TB] FAIL %s: got 0x%0h, want 0x%0h at %0t", name, actual, expected, $time);
      end
   endtask

   // Every cycle after the first reset, both instances are held against the model.
   always @(negedge clk) begin : compareModel
      if (modelValid) begin
         checkOutput("busyOld",    32'(busy0),    32'(expBusy));
         checkOutput("validOld",   32'(rdValid0), 32'(expValid));
         checkOutput("dataOld",    32'(rdData0),  32'(expData0));
         checkOutput("busyNew",    32'(busy1),    32'(expBusy));
         checkOutput("validNew",   32'(rdValid1), 32'(expValid));
         checkOutput("dataNew",    32'(rdData1),  32'(expData1));
      end
   end

   task automatic applyStimulus(input logic r, input logic we, input logic [AW-1:0] wa,
                                input logic [SIZE-1:0] wd, input logic [NL-1:0] wm,
                                input logic re, input logic [AW-1:0] ra);
      rst = r; wrEn = we; wrAddr = wa; wrData = wd; wrMask = wm; rdEn = re; rdAddr = ra;
      @(negedge clk);
   endtask

   task automatic randomCycle(input logic r);
      applyStimulus(r, 1'($urandom_range(0, 1)), AW'($urandom_range(0, DEPTH - 1)),
                    SIZE'($urandom), NL'($urandom), 1'($urandom_range(0, 1)),
                    AW'($urandom_range(0, DEPTH - 1)));
   endtask

   task automatic countBusy(output int n);
      n = 0;
      while (busy0 && n < 200) begin
         randomCycle(1'b0);
         n++;
      end
   endtask

   task automatic readCheck(input string name, input logic [AW-1:0] a,
                            input logic [SIZE-1:0] want0, input logic [SIZE-1:0] want1);
      applyStimulus(1'b0, 1'b0, '0, '0, '0, 1'b1, a);
      checkOutput({name, "Valid"}, 32'(rdValid0), 32'd1);
      checkOutput({name, "Old"},   32'(rdData0),  32'(want0));
      checkOutput({name, "New"},   32'(rdData1),  32'(want1));
   endtask

   initial begin : stimulus
      int n;
      logic [SIZE-1:0] word;
      rst = 1'b1; wrEn = 1'b0; wrAddr = '0; wrData = '0; wrMask = '0; rdEn = 1'b0; rdAddr = '0;

      repeat (3) applyStimulus(1'b1, 1'b0, '0, '0, '0, 1'b1, '0);
      checkOutput("rstBusy",  32'(busy0),    32'd1);
      checkOutput("rstValid", 32'(rdValid0), 32'd0);
      checkOutput("rstData",  32'(rdData0),  32'd0);

      countBusy(n);
      checkOutput("sweepLen", 32'(n), 32'd64);

      readCheck("clr0",  6'd0,  16'h0000, 16'h0000);
      readCheck("clr31", 6'd31, 16'h0000, 16'h0000);
      readCheck("clr63", 6'd63, 16'h0000, 16'h0000);

      applyStimulus(1'b0, 1'b1, 6'd5, 16'hABCD, 2'b01, 1'b0, '0);
      readCheck("laneLo", 6'd5, 16'h00CD, 16'h00CD);
      applyStimulus(1'b0, 1'b1, 6'd5, 16'h1200, 2'b10, 1'b0, '0);
      readCheck("laneHi", 6'd5, 16'h12CD, 16'h12CD);
      applyStimulus(1'b0, 1'b1, 6'd5, 16'hFFFF, 2'b00, 1'b0, '0);
      readCheck("maskNone", 6'd5, 16'h12CD, 16'h12CD);

      applyStimulus(1'b0, 1'b1, 6'd7, 16'h1111, 2'b11, 1'b0, '0);
      applyStimulus(1'b0, 1'b1, 6'd7, 16'h2222, 2'b11, 1'b1, 6'd7);
      checkOutput("rdwOld", 32'(rdData0), 32'h1111);
      checkOutput("rdwNew", 32'(rdData1), 32'h2222);
      readCheck("rdwAfter", 6'd7, 16'h2222, 16'h2222);

      for (int i = 0; i < 1500; i++) randomCycle(($urandom_range(0, 399) == 0) ? 1'b1 : 1'b0);

      applyStimulus(1'b1, 1'b0, '0, '0, '0, 1'b0, '0);
      for (int i = 0; i < 30; i++) begin
         if (i == 10) applyStimulus(1'b0, 1'b1, 6'd3, 16'hBEEF, 2'b11, 1'b1, 6'd3);
         else         randomCycle(1'b0);
      end
      applyStimulus(1'b1, 1'b0, '0, '0, '0, 1'b0, '0);
      countBusy(n);
      checkOutput("restartLen", 32'(n), 32'd64);
      readCheck("sweepWr", 6'd3, 16'h0000, 16'h0000);

      for (int i = 0; i < DEPTH; i++) begin
         word = SIZE'((i * 16'h0101) ^ 16'h5A3C);
         applyStimulus(1'b0, 1'b1, AW'(i), word, 2'b11, 1'b0, '0);
      end
      n = 0;
      for (int i = 0; i < DEPTH; i++) begin
         word = SIZE'((i * 16'h0101) ^ 16'h5A3C);
         applyStimulus(1'b0, 1'b0, '0, '0, '0, 1'b1, AW'(i));
         if (rdValid0 && rdData0 == word) n++;
      end
      checkOutput("streamHits", 32'(n), 32'd64);
      applyStimulus(1'b0, 1'b0, '0, '0, '0, 1'b0, '0);
      checkOutput("streamEnd", 32'(rdValid0), 32'd0);

      applyStimulus(1'b0, 1'b0, '0, '0, '0, 1'b1, 6'd9);
      applyStimulus(1'b1, 1'b0, '0, '0, '0, 1'b1, 6'd9);
      checkOutput("abandonValid", 32'(rdValid0), 32'd0);
      checkOutput("abandonData",  32'(rdData0),  32'd0);
      checkOutput("abandonBusy",  32'(busy0),    32'd1);
      countBusy(n);
      checkOutput("finalLen", 32'(n), 32'd64);
      repeat (4) randomCycle(1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
